ps2_scancode_rx: RTL

- Parametrised next-generation PS/2 keyboard receiver.
- Deglitches and synchronises the PS/2 clock and data lines, then deserialises 11-bit frames with full start, parity and stop checking.
- Folds E0 and F0 prefixes into single key events and buffers the events in a FIFO with a valid/ready handshake.
- Sits between the board PS/2 pins and any keycode consumer (text console, game logic).

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_event_fifo.sv | 55 +++++
 rtl/ps2_scancode_rx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, FSM state and event type for the PS/2 receiver
package ps2_pkg;
    localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    localparam int PS2_EVENT_W = 10;
endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - synchronous event FIFO with wrap-bit pointers and sticky overflow
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  ps2_event_t push_data,
    input  logic       pop,
    output ps2_event_t head,
    output logic       full,
    output logic       empty,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [PS2_EVENT_W-1:0] mem_q [DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                   overflow_q, overflow_d;
    logic                   do_push, do_pop;

    assign empty    = wr_ptr_q == rd_ptr_q;
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head     = ps2_event_t'(mem_q[rd_ptr_q[AW-1:0]]);
    assign overflow = overflow_q;

    always_comb begin
        do_pop     = pop && !empty;
        // A pop in the same cycle frees the slot, so a push at full still lands.
        do_push    = push && (!full || do_pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q || (push && !do_push);
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard receiver: line conditioning, framing, prefix folding, event FIFO
// Optional PS2_TYPEMATIC_SUPPRESS_EN: repeated make events of the held key are not pushed.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       frame_err,
    output logic       overflow
);
    localparam int FW        = $clog2(FILTER_LEN + 1);
    localparam int TW        = $clog2(TIMEOUT_CYC + 1);
    localparam int DATA_BITS = PS2_FRAME_BITS - 3;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic [FW-1:0]          flt_cnt_q, flt_cnt_d;
    logic                   flt_q, flt_d, strobe_q, strobe_d;
    logic                   clk_s, dat_s;
    ps2_state_e             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d, frame_err_q, frame_err_d, byte_good;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d, push_q, push_d;
    ps2_event_t             ev_q, ev_d, fifo_head;
    logic                   fifo_full, fifo_empty;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
    logic                   held_valid_q, held_valid_d, held_ext_q, held_ext_d, held_hit;
    logic [7:0]             held_code_q, held_code_d;
    assign held_hit = held_valid_q && (held_ext_q == ext_pend_q) && (held_code_q == shift_q);
`endif

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
        flt_d      = flt_q;
        flt_cnt_d  = '0;
        strobe_d   = 1'b0;
        if (clk_s != flt_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                flt_d    = clk_s;
                strobe_d = flt_q;  // a flip away from 1 is a falling edge
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = '0;
        byte_good   = 1'b0;
        frame_err_d = 1'b0;
        if (state_q != ST_IDLE && !strobe_q) tmo_d = tmo_q + 1'b1;
        if (strobe_q) begin
            case (state_q)
                ST_IDLE: if (!dat_s) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
                ST_DATA: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = dat_s;
                    state_d = ST_STOP;
                end
                default: begin
                    byte_good   = dat_s && (^{shift_q, par_q});
                    frame_err_d = !byte_good;
                    state_d     = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end
    end

    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        push_d     = 1'b0;
        ev_d       = ev_q;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
        held_valid_d = held_valid_q;
        held_ext_d   = held_ext_q;
        held_code_d  = held_code_q;
`endif
        if (frame_err_d) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (byte_good) begin
            if (shift_q == PS2_PFX_EXT) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == PS2_PFX_BRK) begin
                brk_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
                push_d     = 1'b1;
                ev_d       = '{ext: ext_pend_q, brk: brk_pend_q, code: shift_q};
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
                if (brk_pend_q) begin
                    if (held_hit) held_valid_d = 1'b0;
                end else if (held_hit) begin
                    push_d = 1'b0;
                end else begin
                    held_valid_d = 1'b1;
                    held_ext_d   = ext_pend_q;
                    held_code_d  = shift_q;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            flt_q       <= 1'b1;
            flt_cnt_q   <= '0;
            strobe_q    <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            push_q      <= 1'b0;
            ev_q        <= '0;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
            held_valid_q <= 1'b0;
            held_ext_q   <= 1'b0;
            held_code_q  <= '0;
`endif
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            flt_q       <= flt_d;
            flt_cnt_q   <= flt_cnt_d;
            strobe_q    <= strobe_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            push_q      <= push_d;
            ev_q        <= ev_d;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
            held_valid_q <= held_valid_d;
            held_ext_q   <= held_ext_d;
            held_code_q  <= held_code_d;
`endif
        end
    end

    ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (ev_q),
        .pop       (ev_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    // Memory contents are unreset, so the head fields are masked while empty.
    assign ev_valid  = !fifo_empty;
    assign ev_code   = ev_valid ? fifo_head.code : 8'h00;
    assign ev_ext    = ev_valid && fifo_head.ext;
    assign ev_brk    = ev_valid && fifo_head.brk;
    assign frame_err = frame_err_q;
endmodule
